// File: rtl/qa7_seg_tty_pkg.sv
// rtl/qa7_seg_tty_pkg.sv - glyph constants, FSM states and hex font for the QA7 tty display sink
package qa7_seg_tty_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2,
        ST_HALT = 2'd3
    } tty_state_t;

    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_O     = 8'h5C;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segments a..g on bits 0..6; the dp bit is handled separately by the caller.
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/qa7_tty_fifo.sv
// rtl/qa7_tty_fifo.sv - small synchronous byte FIFO on a plain register array
module qa7_tty_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Full/empty are taken from the pre-update count, so a push on full is
    // refused even when a pop happens in the same cycle.
    assign w_push = push & (r_count != FULL_CNT);
    assign w_pop  = pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);
    assign count = r_count;

endmodule

// File: rtl/qa7_seg_tty.sv
// rtl/qa7_seg_tty.sv - tty debug byte stream to three 7-segment glyphs with status digit
module qa7_seg_tty #(
    parameter int FIFO_AW = 4,
    parameter int HOLD_MS = 500,
    parameter int HOLD_W  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_ms,
    input  logic       tty_stb,
    input  logic [7:0] tty_dat,
    input  logic       tty_end,
    output logic [7:0] seg_hex0,
    output logic [7:0] seg_hex1,
    output logic [7:0] seg_hex2,
    output logic       tty_ovf,
    output logic       tty_idle
);

    import qa7_seg_tty_pkg::*;

    tty_state_t        r_state;
    tty_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [7:0]        r_disp;
    logic [7:0]        w_disp_nxt;
    logic              r_shown;
    logic              w_shown_nxt;
    logic              r_end_seen;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic [6:0]        r_seg_hi;
    logic [6:0]        r_seg_lo;
    logic              r_dp;
    logic [7:0]        r_seg_st;
    logic [7:0]        w_seg_st_nxt;
    logic              r_idle;

    logic [7:0]        w_fifo_dout;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [FIFO_AW:0]  w_fifo_count;
    logic [FIFO_AW:0]  w_cnt_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    assign w_push = tty_stb & ~w_fifo_full;
    assign w_drop = tty_stb & w_fifo_full;
    assign w_pop  = (r_state == ST_LOAD);

    qa7_tty_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (tty_dat),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    // Output registers are fed from next-state values so glyphs change on
    // the same edge that leaves LOAD.
    assign w_cnt_nxt   = w_fifo_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
    assign w_ovf_nxt   = r_ovf | w_drop;
    assign w_disp_nxt  = w_pop ? w_fifo_dout : r_disp;
    assign w_shown_nxt = r_shown | w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_LOAD;
                end else if (r_end_seen) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_LOAD: begin
                w_hold_nxt  = HOLD_W'(HOLD_MS - 1);
                w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (ena_ms) begin
                    if (r_hold == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_hold_nxt = r_hold - HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    always_comb begin
        w_seg_st_nxt = SEG_BLANK;
        if (w_state_nxt == ST_HALT) begin
            w_seg_st_nxt = SEG_E;
        end else if (w_ovf_nxt) begin
            w_seg_st_nxt = SEG_O;
        end else if (w_state_nxt == ST_SHOW) begin
            w_seg_st_nxt = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_disp     <= '0;
            r_shown    <= 1'b0;
            r_end_seen <= 1'b0;
            r_ovf      <= 1'b0;
            r_seg_hi   <= '0;
            r_seg_lo   <= '0;
            r_dp       <= 1'b0;
            r_seg_st   <= SEG_BLANK;
            r_idle     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_disp     <= w_disp_nxt;
            r_shown    <= w_shown_nxt;
            r_end_seen <= r_end_seen | tty_end;
            r_ovf      <= w_ovf_nxt;
            r_seg_hi   <= w_shown_nxt ? seg_font(w_disp_nxt[7:4]) : 7'h00;
            r_seg_lo   <= w_shown_nxt ? seg_font(w_disp_nxt[3:0]) : 7'h00;
            r_dp       <= (w_cnt_nxt != '0);
            r_seg_st   <= w_seg_st_nxt;
            r_idle     <= (w_cnt_nxt == '0) &&
                          ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HALT));
        end
    end

    assign seg_hex0 = {r_dp, r_seg_lo};
    assign seg_hex1 = {1'b0, r_seg_hi};
    assign seg_hex2 = r_seg_st;
    assign tty_ovf  = r_ovf;
    assign tty_idle = r_idle;

endmodule
